// File: rtl/wb_commit_queue.sv
// Write-back commit queue: in-order FIFO of completed instructions whose head is
// retired by a small FSM. Define WB_TRACE_EN to drive the dbg_* trace port.
module wb_commit_queue #(
    parameter int DEPTH       = 2,
    parameter int CSR_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_allowin,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_result,
    input  logic        in_gr_we,
    input  logic [4:0]  in_dest,
    input  logic        in_csr_re,
    input  logic        in_ex,
    input  logic [5:0]  in_ecode,
    input  logic        in_ertn,
    output logic        csr_req,
    input  logic        csr_ack,
    input  logic [31:0] csr_rvalue,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        ex_commit,
    output logic [5:0]  ex_ecode,
    output logic [31:0] ex_pc,
    output logic        ertn_commit,
    output logic        flush,
    output logic [31:0] retire_cnt,
    output logic [31:0] dbg_pc,
    output logic [3:0]  dbg_wen,
    output logic [4:0]  dbg_wnum,
    output logic [31:0] dbg_wdata
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = (CSR_TIMEOUT > 1) ? $clog2(CSR_TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LOAD = TW'(CSR_TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CSR_WAIT,
        S_FLUSH
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] result;
        logic        gr_we;
        logic [4:0]  dest;
        logic        csr_re;
        logic        ex;
        logic [5:0]  ecode;
        logic        ertn;
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          head_e;
    state_t          state_q, state_d;
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [31:0]     retire_cnt_q, retire_cnt_d;

    logic            head_vld;
    logic            retire;
    logic            do_flush;
    logic            wr_en;
    logic [31:0]     wr_data;
    logic            push;

    assign head_e   = mem_q[head_q];
    assign head_vld = (count_q != '0);

    // Head decode; ex outranks ertn, which outranks a CSR read.
    always_comb begin
        retire      = 1'b0;
        do_flush    = 1'b0;
        csr_req     = 1'b0;
        ex_commit   = 1'b0;
        ertn_commit = 1'b0;
        wr_en       = 1'b0;
        wr_data     = head_e.result;
        state_d     = state_q;
        tmo_d       = tmo_q;
        unique case (state_q)
            S_IDLE: begin
                if (head_vld) begin
                    if (head_e.ex) begin
                        ex_commit = 1'b1;
                        do_flush  = 1'b1;
                        state_d   = S_FLUSH;
                    end else if (head_e.ertn) begin
                        ertn_commit = 1'b1;
                        do_flush    = 1'b1;
                        state_d     = S_FLUSH;
                    end else if (head_e.csr_re) begin
                        csr_req = 1'b1;
                        tmo_d   = TMO_LOAD;
                        state_d = S_CSR_WAIT;
                    end else begin
                        retire = 1'b1;
                        wr_en  = head_e.gr_we && (head_e.dest != 5'd0);
                    end
                end
            end
            S_CSR_WAIT: begin
                if (csr_ack) begin
                    retire  = 1'b1;
                    wr_en   = (head_e.dest != 5'd0);
                    wr_data = csr_rvalue;
                    tmo_d   = '0;
                    state_d = S_IDLE;
                end else if (tmo_q == '0) begin
                    retire  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q - TW'(1);
                end
            end
            S_FLUSH: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // A full queue still accepts when the head leaves in the same cycle.
    assign in_allowin = (state_q != S_FLUSH) && ((count_q != CNT_FULL) || retire);
    assign push       = in_valid && in_allowin;

    always_comb begin
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        retire_cnt_d = retire_cnt_q;
        if (retire) retire_cnt_d = retire_cnt_q + 32'd1;
        if (do_flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (retire) head_d = head_q + PW'(1);
            if (push)   tail_d = tail_q + PW'(1);
            if (push && !retire)      count_d = count_q + CW'(1);
            else if (!push && retire) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            tmo_q        <= '0;
            retire_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            tmo_q        <= tmo_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[tail_q] <= '{pc: in_pc, result: in_result, gr_we: in_gr_we, dest: in_dest,
                               csr_re: in_csr_re, ex: in_ex, ecode: in_ecode, ertn: in_ertn};
        end
    end

    assign rf_we      = wr_en;
    assign rf_waddr   = wr_en ? head_e.dest : 5'd0;
    assign rf_wdata   = wr_en ? wr_data : 32'd0;
    assign ex_ecode   = ex_commit ? head_e.ecode : 6'd0;
    assign ex_pc      = ex_commit ? head_e.pc : 32'd0;
    assign flush      = do_flush;
    assign retire_cnt = retire_cnt_q;

`ifdef WB_TRACE_EN
    assign dbg_pc    = retire ? head_e.pc : 32'd0;
    assign dbg_wen   = {4{rf_we}};
    assign dbg_wnum  = rf_waddr;
    assign dbg_wdata = rf_wdata;
`else
    assign dbg_pc    = 32'd0;
    assign dbg_wen   = 4'd0;
    assign dbg_wnum  = 5'd0;
    assign dbg_wdata = 32'd0;
`endif

endmodule

// File: tb/tb_wb_commit_queue.sv
// Directed bench for wb_commit_queue (DEPTH=4): table of single-cycle vectors
// plus hand sequences for exception flush, CSR timeout, full-queue streaming and reset.
module tb_wb_commit_queue;

    localparam int DEPTH = 4;
    localparam int TMO   = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_allowin;
    logic [31:0] in_pc, in_result;
    logic        in_gr_we;
    logic [4:0]  in_dest;
    logic        in_csr_re, in_ex, in_ertn;
    logic [5:0]  in_ecode;
    logic        csr_req, csr_ack;
    logic [31:0] csr_rvalue;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        ex_commit;
    logic [5:0]  ex_ecode;
    logic [31:0] ex_pc;
    logic        ertn_commit, flush;
    logic [31:0] retire_cnt;
    logic [31:0] dbg_pc;
    logic [3:0]  dbg_wen;
    logic [4:0]  dbg_wnum;
    logic [31:0] dbg_wdata;

    always #5 clk = ~clk;

    wb_commit_queue #(.DEPTH(DEPTH), .CSR_TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_allowin(in_allowin),
        .in_pc(in_pc), .in_result(in_result),
        .in_gr_we(in_gr_we), .in_dest(in_dest), .in_csr_re(in_csr_re),
        .in_ex(in_ex), .in_ecode(in_ecode), .in_ertn(in_ertn),
        .csr_req(csr_req), .csr_ack(csr_ack), .csr_rvalue(csr_rvalue),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .ex_commit(ex_commit), .ex_ecode(ex_ecode), .ex_pc(ex_pc),
        .ertn_commit(ertn_commit), .flush(flush), .retire_cnt(retire_cnt),
        .dbg_pc(dbg_pc), .dbg_wen(dbg_wen), .dbg_wnum(dbg_wnum), .dbg_wdata(dbg_wdata)
    );

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic [31:0] res;
        logic        we;
        logic [4:0]  dest;
        logic        csr;
        logic        ex;
        logic [5:0]  ec;
        logic        ertn;
        logic        ack;
        logic [31:0] rval;
        logic        a_allow;
        logic        a_we;
        logic [4:0]  a_wa;
        logic [31:0] a_wd;
        logic        a_cr;
        logic        a_ex;
        logic [5:0]  a_ec;
        logic [31:0] a_pc;
        logic        a_er;
        logic        a_fl;
        logic [31:0] a_rc;
    } vec_t;

    vec_t tv [18];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic e_allow, input logic e_we,
                           input logic [4:0] e_wa, input logic [31:0] e_wd, input logic e_cr,
                           input logic e_ex, input logic [5:0] e_ec, input logic [31:0] e_pc,
                           input logic e_er, input logic e_fl, input logic [31:0] e_rc);
        #2;
        chk({tag, " in_allowin"},  32'(in_allowin),  32'(e_allow));
        chk({tag, " rf_we"},       32'(rf_we),       32'(e_we));
        chk({tag, " rf_waddr"},    32'(rf_waddr),    32'(e_wa));
        chk({tag, " rf_wdata"},    rf_wdata,         e_wd);
        chk({tag, " csr_req"},     32'(csr_req),     32'(e_cr));
        chk({tag, " ex_commit"},   32'(ex_commit),   32'(e_ex));
        chk({tag, " ex_ecode"},    32'(ex_ecode),    32'(e_ec));
        chk({tag, " ex_pc"},       ex_pc,            e_pc);
        chk({tag, " ertn_commit"}, 32'(ertn_commit), 32'(e_er));
        chk({tag, " flush"},       32'(flush),       32'(e_fl));
        chk({tag, " retire_cnt"},  retire_cnt,       e_rc);
`ifdef WB_TRACE_EN
        chk({tag, " dbg_wen"},     32'(dbg_wen),     32'({4{e_we}}));
        chk({tag, " dbg_wdata"},   dbg_wdata,        e_wd);
`else
        chk({tag, " dbg_wen"},     32'(dbg_wen),     32'd0);
        chk({tag, " dbg_wdata"},   dbg_wdata,        32'd0);
`endif
    endtask

    task automatic idle_in();
        in_valid = 1'b0; in_pc = 32'd0; in_result = 32'd0; in_gr_we = 1'b0;
        in_dest = 5'd0; in_csr_re = 1'b0; in_ex = 1'b0; in_ecode = 6'd0;
        in_ertn = 1'b0; csr_ack = 1'b0; csr_rvalue = 32'd0;
    endtask

    task automatic push_in(input logic [31:0] pc, input logic [31:0] res, input logic we,
                           input logic [4:0] d, input logic c, input logic e,
                           input logic [5:0] ec, input logic er);
        in_valid = 1'b1; in_pc = pc; in_result = res; in_gr_we = we; in_dest = d;
        in_csr_re = c; in_ex = e; in_ecode = ec; in_ertn = er;
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int sb [$];
        int j;
        tv[0]  = '{1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 6'h00, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 6'h00, 32'h0, 1'b0, 1'b0, 32'd0};
        tv[1]  = '{1'b1, 32'h1c000000, 32'h1234, 1'b1, 5'd5, 1'b0, 1'b0, 6'h00, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 6'h00, 32'h0, 1'b0, 1'b0, 32'd0};
        tv[2]  = '{1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 6'h00, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 5'd5, 32'h1234, 1'b0, 1'b0, 6'h00, 32'h0, 1'b0, 1'b0, 32'd0};
        tv[3]  = '{1'b1, 32'h1c000004, 32'h5555, 1'b1, 5'd0, 1'b0, 1'b0, 6'h00, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 6'h00, 32'h0, 1'b0, 1'b0, 32'd1};
        tv[4]  = '{1'b1, 32'h1c000008, 32'h7777, 1'b0, 5'd7, 1'b0, 1'b0, 6'h00, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 6'h00, 32'h0, 1'b0, 1'b0, 32'd1};
        tv[5]  = '{1'b1, 32'h1c00000c, 32'h0, 1'b1, 5'd4, 1'b1, 1'b0, 6'h00, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 6'h00, 32'h0, 1'b0, 1'b0, 32'd2};
        tv[6]  = '{1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 6'h00, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 6'h00, 32'h0, 1'b0, 1'b0, 32'd3};
        tv[7]  = '{1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 6'h00, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 6'h00, 32'h0, 1'b0, 1'b0, 32'd3};
        tv[8]  = '{1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 6'h00, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 6'h00, 32'h0, 1'b0, 1'b0, 32'd3};
        tv[9]  = '{1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 6'h00, 1'b0, 1'b1, 32'hABCD,  1'b1, 1'b1, 5'd4, 32'hABCD, 1'b0, 1'b0, 6'h00, 32'h0, 1'b0, 1'b0, 32'd3};
        tv[10] = '{1'b1, 32'h1c000010, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 6'h00, 1'b1, 1'b0, 32'h0,  1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 6'h00, 32'h0, 1'b0, 1'b0, 32'd4};
        tv[11] = '{1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 6'h00, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 6'h00, 32'h0, 1'b1, 1'b1, 32'd4};
        tv[12] = '{1'b1, 32'h1c000014, 32'hF, 1'b1, 5'd10, 1'b0, 1'b0, 6'h00, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 6'h00, 32'h0, 1'b0, 1'b0, 32'd4};
        tv[13] = '{1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 6'h00, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 6'h00, 32'h0, 1'b0, 1'b0, 32'd4};
        tv[14] = '{1'b1, 32'h1c000040, 32'h0, 1'b0, 5'd0, 1'b0, 1'b1, 6'h0B, 1'b1, 1'b0, 32'h0,  1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 6'h00, 32'h0, 1'b0, 1'b0, 32'd4};
        tv[15] = '{1'b1, 32'h1c000044, 32'h99, 1'b1, 5'd9, 1'b0, 1'b0, 6'h00, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 6'h0B, 32'h1c000040, 1'b0, 1'b1, 32'd4};
        tv[16] = '{1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 6'h00, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 6'h00, 32'h0, 1'b0, 1'b0, 32'd4};
        tv[17] = '{1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 6'h00, 1'b0, 1'b1, 32'h55,  1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 6'h00, 32'h0, 1'b0, 1'b0, 32'd4};

        reset = 1'b1;
        idle_in();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < 18; i++) begin
            in_valid = tv[i].v; in_pc = tv[i].pc; in_result = tv[i].res; in_gr_we = tv[i].we;
            in_dest = tv[i].dest; in_csr_re = tv[i].csr; in_ex = tv[i].ex; in_ecode = tv[i].ec;
            in_ertn = tv[i].ertn; csr_ack = tv[i].ack; csr_rvalue = tv[i].rval;
            chk_out($sformatf("v%0d", i), tv[i].a_allow, tv[i].a_we, tv[i].a_wa, tv[i].a_wd,
                    tv[i].a_cr, tv[i].a_ex, tv[i].a_ec, tv[i].a_pc, tv[i].a_er, tv[i].a_fl, tv[i].a_rc);
            next_cyc();
        end
        idle_in();

        // Exception on second entry: later entries never reach the register file.
        push_in(32'h1c000100, 32'h11, 1'b1, 5'd1, 1'b0, 1'b0, 6'h00, 1'b0);
        chk_out("exq a", 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 6'h00, 32'h0, 1'b0, 1'b0, 32'd4);
        next_cyc();
        push_in(32'h1c000104, 32'h22, 1'b1, 5'd2, 1'b0, 1'b1, 6'h0B, 1'b0);
        chk_out("exq b", 1'b1, 1'b1, 5'd1, 32'h11, 1'b0, 1'b0, 6'h00, 32'h0, 1'b0, 1'b0, 32'd4);
        next_cyc();
        push_in(32'h1c000108, 32'h33, 1'b1, 5'd3, 1'b0, 1'b0, 6'h00, 1'b0);
        chk_out("exq c", 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 6'h0B, 32'h1c000104, 1'b0, 1'b1, 32'd5);
        next_cyc();
        push_in(32'h1c00010c, 32'h44, 1'b1, 5'd4, 1'b0, 1'b0, 6'h00, 1'b0);
        chk_out("exq d", 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 6'h00, 32'h0, 1'b0, 1'b0, 32'd5);
        next_cyc();
        idle_in();
        chk_out("exq e", 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 6'h00, 32'h0, 1'b0, 1'b0, 32'd5);
        next_cyc();
        chk_out("exq f", 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 6'h00, 32'h0, 1'b0, 1'b0, 32'd5);
        next_cyc();

        // CSR read never acknowledged: forced retirement without a write.
        push_in(32'h1c000200, 32'h0, 1'b1, 5'd6, 1'b1, 1'b0, 6'h00, 1'b0);
        chk_out("tmo push", 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 6'h00, 32'h0, 1'b0, 1'b0, 32'd5);
        next_cyc();
        idle_in();
        chk_out("tmo req", 1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 6'h00, 32'h0, 1'b0, 1'b0, 32'd5);
        next_cyc();
        for (int k = 1; k <= TMO; k++) begin
            chk_out($sformatf("tmo w%0d", k), 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 6'h00, 32'h0, 1'b0, 1'b0, 32'd5);
            next_cyc();
        end
        chk_out("tmo done", 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 6'h00, 32'h0, 1'b0, 1'b0, 32'd6);
        next_cyc();

        // Fill behind a stalled CSR head, then stream one push and one retire per cycle.
        push_in(32'h1c000300, 32'h0, 1'b1, 5'd2, 1'b1, 1'b0, 6'h00, 1'b0);
        chk_out("full x", 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 6'h00, 32'h0, 1'b0, 1'b0, 32'd6);
        next_cyc();
        for (int k = 1; k <= 3; k++) begin
            push_in(32'h1c001000 + 32'(k * 4), 32'h1000 + 32'(k), 1'b1, 5'(k), 1'b0, 1'b0, 6'h00, 1'b0);
            chk_out($sformatf("full n%0d", k), 1'b1, 1'b0, 5'd0, 32'h0, (k == 1), 1'b0, 6'h00, 32'h0, 1'b0, 1'b0, 32'd6);
            sb.push_back(k);
            next_cyc();
        end
        push_in(32'h1c001010, 32'h1004, 1'b1, 5'd4, 1'b0, 1'b0, 6'h00, 1'b0);
        chk_out("full stall", 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 6'h00, 32'h0, 1'b0, 1'b0, 32'd6);
        next_cyc();
        csr_ack = 1'b1; csr_rvalue = 32'h0000_00CC;
        chk_out("full ack", 1'b1, 1'b1, 5'd2, 32'hCC, 1'b0, 1'b0, 6'h00, 32'h0, 1'b0, 1'b0, 32'd6);
        sb.push_back(4);
        next_cyc();
        csr_ack = 1'b0; csr_rvalue = 32'd0;
        for (int k = 5; k <= 12; k++) begin
            push_in(32'h1c001000 + 32'(k * 4), 32'h1000 + 32'(k), 1'b1, 5'(k), 1'b0, 1'b0, 6'h00, 1'b0);
            j = sb.pop_front();
            chk_out($sformatf("stream k%0d", k), 1'b1, 1'b1, 5'(j), 32'h1000 + 32'(j), 1'b0, 1'b0, 6'h00, 32'h0,
                    1'b0, 1'b0, 32'd7 + 32'(k - 5));
            sb.push_back(k);
            next_cyc();
        end
        idle_in();
        for (int m = 0; m < 4; m++) begin
            j = sb.pop_front();
            chk_out($sformatf("drain m%0d", m), 1'b1, 1'b1, 5'(j), 32'h1000 + 32'(j), 1'b0, 1'b0, 6'h00, 32'h0,
                    1'b0, 1'b0, 32'd15 + 32'(m));
            next_cyc();
        end
        chk_out("drain end", 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 6'h00, 32'h0, 1'b0, 1'b0, 32'd19);
        next_cyc();

        // Reset while waiting on a CSR; the late ack must be ignored.
        push_in(32'h1c000400, 32'h0, 1'b1, 5'd3, 1'b1, 1'b0, 6'h00, 1'b0);
        chk_out("rst push", 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 6'h00, 32'h0, 1'b0, 1'b0, 32'd19);
        next_cyc();
        idle_in();
        chk_out("rst req", 1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 6'h00, 32'h0, 1'b0, 1'b0, 32'd19);
        next_cyc();
        chk_out("rst wait", 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 6'h00, 32'h0, 1'b0, 1'b0, 32'd19);
        reset = 1'b1;
        next_cyc();
        reset = 1'b0;
        csr_ack = 1'b1; csr_rvalue = 32'hDEAD;
        chk_out("rst ack", 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 6'h00, 32'h0, 1'b0, 1'b0, 32'd0);
        next_cyc();
        idle_in();
        push_in(32'h1c000500, 32'h88, 1'b1, 5'd8, 1'b0, 1'b0, 6'h00, 1'b0);
        chk_out("rst z", 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 6'h00, 32'h0, 1'b0, 1'b0, 32'd0);
        next_cyc();
        idle_in();
        chk_out("rst z ret", 1'b1, 1'b1, 5'd8, 32'h88, 1'b0, 1'b0, 6'h00, 32'h0, 1'b0, 1'b0, 32'd0);
        next_cyc();
        chk_out("rst z cnt", 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 6'h00, 32'h0, 1'b0, 1'b0, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/wb_commit_queue.md
WB_COMMIT_QUEUE -- requirements
Module: wb_commit_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 2, number of commit-queue entries; legal values 2, 4, 8.
REQ-002 SHALL have parameter CSR_TIMEOUT, default 15, maximum cycles to wait for csr_ack before forcing a commit.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 in_valid  in  1  upstream instruction valid.
REQ-006 in_allowin  out  1  queue can accept an entry this cycle.
REQ-007 in_pc / in_result  in  32 / 32  instruction PC / ALU-or-load result.
REQ-008 in_gr_we, in_dest, in_csr_re  in  1, 5, 1  GPR write enable, destination, CSR-read flag.
REQ-009 in_ex, in_ecode, in_ertn  in  1, 6, 1  exception flag, exception code, ertn flag.
REQ-010 csr_req  out  1  CSR read request for the head entry.
REQ-011 csr_ack, csr_rvalue  in  1, 32  CSR read done, read data.
REQ-012 rf_we, rf_waddr, rf_wdata  out  1, 5, 32  register-file write port.
REQ-013 ex_commit, ex_ecode, ex_pc  out  1, 6, 32  exception commit pulse to CSR unit.
REQ-014 ertn_commit, flush  out  1, 1  ertn commit pulse; pipeline flush pulse.
REQ-015 retire_cnt  out  32  committed-instruction count.
REQ-016 dbg_pc, dbg_wen, dbg_wnum, dbg_wdata  out  32, 4, 5, 32  trace port.

Function
REQ-017 Queue SHALL be a circular FIFO of DEPTH entries; push when in_valid && in_allowin; in_allowin = !full || head retiring this cycle.
REQ-018 Head entry SHALL be processed by FSM with states IDLE, CSR_WAIT, FLUSH.
REQ-019 IDLE, head valid, no ex/ertn/csr_re: entry SHALL retire that cycle; rf_we = in_gr_we && in_dest != 0, rf_wdata = result.
REQ-020 IDLE, head csr_re: csr_req SHALL pulse one cycle, FSM -> CSR_WAIT; head not retired.
REQ-021 CSR_WAIT: on csr_ack, head SHALL retire same cycle writing csr_rvalue to dest (if dest != 0), FSM -> IDLE.
REQ-022 CSR_WAIT: timeout counter reaching CSR_TIMEOUT without ack SHALL retire head with rf_we=0, FSM -> IDLE.
REQ-023 IDLE, head in_ex: ex_commit, ex_ecode, ex_pc and flush SHALL pulse one cycle, no rf write, FSM -> FLUSH.
REQ-024 IDLE, head in_ertn (no ex): ertn_commit and flush SHALL pulse one cycle, FSM -> FLUSH; in_ex takes priority if both set.
REQ-025 On flush cycle all queue entries SHALL be discarded, including any entry pushed that cycle; pointers and count cleared next edge.
REQ-026 FLUSH: in_allowin SHALL be 0 for exactly one cycle, then FSM -> IDLE.
REQ-027 Full and retiring in the same cycle: push SHALL be accepted; count unchanged.
REQ-028 Pointers SHALL wrap modulo DEPTH; count 0..DEPTH.
REQ-029 retire_cnt SHALL increment by 1 per normal or CSR retirement (incl. timeout), not for ex/ertn; wraps at 2^32.
REQ-030 Latency: entry pushed into empty queue in IDLE SHALL retire the next cycle at earliest.
REQ-031 All outputs except in_allowin and retire_cnt SHALL be combinational from head state/FSM; no output X when queue empty.

Reset
REQ-032 On reset: queue empty, FSM IDLE, timeout counter 0, retire_cnt 0.
REQ-033 Outputs after reset: in_allowin 1, csr_req/rf_we/ex_commit/ertn_commit/flush 0, dbg_wen 0.
REQ-034 Reset mid-CSR_WAIT SHALL abandon the request; late csr_ack after reset SHALL be ignored.

Configuration
REQ-035 Macro WB_TRACE_EN defined: dbg_pc = retiring pc, dbg_wen = {4{rf_we}}, dbg_wnum = rf_waddr, dbg_wdata = rf_wdata.
REQ-036 WB_TRACE_EN undefined: dbg_* SHALL be tied to 0 and no trace logic synthesised.

Verification
REQ-037 Push pc=0x1c000000, gr_we=1, dest=5, result=0x1234 into empty queue -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234, retire_cnt=1.
REQ-038 Push csr_re, dest=4; ack after 3 cycles with csr_rvalue=0xABCD -> csr_req single pulse, rf_wdata=0xABCD on ack cycle.
REQ-039 Fill DEPTH=4 with entry 2 having in_ex, ecode=0x0B -> ex_commit and flush one pulse, ex_pc = entry-2 pc, entries 3-4 never written, in_allowin 0 one cycle.
REQ-040 Csr_re with no ack -> retire with rf_we=0 after CSR_TIMEOUT=15 cycles, retire_cnt +1.
REQ-041 Continuous in_valid with queue full -> one push and one retire per cycle, no entry lost, pointers wrap.
REQ-042 Assert reset during CSR_WAIT, then csr_ack -> no rf_we, queue empty, FSM IDLE.
